// File: rtl/vga_pkg.sv
// Shared constants, FSM encoding and the frame-buffer address helper for the plot sink.
package vga_pkg;

    localparam logic [2:0] BACKGROUND = 3'b111;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned FB_WIDTH  = 320;
    localparam int unsigned FB_HEIGHT = 240;
    localparam int unsigned FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned CNT_W     = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

    // row*width + col as a sum of shifted rows, one term per set bit of the
    // constant width; for width 320 this is (row<<8)+(row<<6)+col.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [8:0] col,
                                                  input logic [7:0] row,
                                                  input int unsigned width);
        logic [ADDR_W-1:0] acc;
        acc = {{(ADDR_W-9){1'b0}}, col};
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            if (((width >> i) & 32'd1) != 32'd0) begin
                acc = acc + ({{(ADDR_W-8){1'b0}}, row} << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel enable, h/v counters, raw syncs, visible flag, frame tick.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS = H_VISIBLE,
    parameter int unsigned H_FP  = H_FRONT,
    parameter int unsigned H_SW  = H_SYNC,
    parameter int unsigned H_BP  = H_BACK,
    parameter int unsigned V_VIS = V_VISIBLE,
    parameter int unsigned V_FP  = V_FRONT,
    parameter int unsigned V_SW  = V_SYNC,
    parameter int unsigned V_BP  = V_BACK
) (
    input  logic       clock,
    input  logic       reset,
    output logic       pix_en,
    output logic [8:0] fb_x,
    output logic [7:0] fb_y,
    output logic       visible,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       frame_tick
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SW + V_BP;

    logic             pix_en_q, pix_en_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             frame_tick_q, frame_tick_d;
    logic             h_last, v_last;

    // Counter advance on every second clock; tick registered as counters wrap to 0,0.
    always_comb begin
        h_last       = (h_q == CNT_W'(H_TOTAL - 1));
        v_last       = (v_q == CNT_W'(V_TOTAL - 1));
        pix_en_d     = ~pix_en_q;
        h_d          = h_q;
        v_d          = v_q;
        frame_tick_d = 1'b0;
        if (pix_en_q) begin
            if (h_last) begin
                h_d          = '0;
                v_d          = v_last ? '0 : v_q + 1'b1;
                frame_tick_d = v_last;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Timing state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_en_q     <= 1'b0;
            h_q          <= '0;
            v_q          <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            pix_en_q     <= pix_en_d;
            h_q          <= h_d;
            v_q          <= v_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Raw (undelayed) raster decode for the current pixel.
    always_comb begin
        visible = (h_q < CNT_W'(H_VIS)) && (v_q < CNT_W'(V_VIS));
        hs_raw  = !((h_q >= CNT_W'(H_VIS + H_FP)) && (h_q < CNT_W'(H_VIS + H_FP + H_SW)));
        vs_raw  = !((v_q >= CNT_W'(V_VIS + V_FP)) && (v_q < CNT_W'(V_VIS + V_FP + V_SW)));
        fb_x    = h_q[9:1];
        fb_y    = v_q[8:1];
    end

    assign pix_en     = pix_en_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: rtl/vga_plot_sink.sv
// Pixel-plot receiver: writes plots into a 3-bit frame buffer, runs clear sweeps,
// and scans the buffer out as VGA with each stored pixel doubled into a 2x2 block.
module vga_plot_sink
    import vga_pkg::*;
#(
    parameter int unsigned FB_W  = FB_WIDTH,
    parameter int unsigned FB_H  = FB_HEIGHT,
    parameter int unsigned H_VIS = H_VISIBLE,
    parameter int unsigned H_FP  = H_FRONT,
    parameter int unsigned H_SW  = H_SYNC,
    parameter int unsigned H_BP  = H_BACK,
    parameter int unsigned V_VIS = V_VISIBLE,
    parameter int unsigned V_FP  = V_FRONT,
    parameter int unsigned V_SW  = V_SYNC,
    parameter int unsigned V_BP  = V_BACK
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       plot,
    input  logic [8:0] x,
    input  logic [7:0] y,
    input  logic [2:0] colour,
    input  logic       clear_screen,
    output logic       busy,
    output logic       plot_dropped,
    output logic       frame_tick,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk
);

    localparam int unsigned DEPTH  = FB_W * FB_H;
    localparam int unsigned MEM_AW = $clog2(DEPTH);

    fb_state_e         state_q, state_d;
    logic [MEM_AW-1:0] clr_addr_q, clr_addr_d;
    logic              drop_q, drop_d;
    logic              in_range;
    logic              we;
    logic [MEM_AW-1:0] waddr, rd_addr;
    logic [2:0]        wdata;

    logic              pix_en, visible, hs_raw, vs_raw;
    logic [8:0]        fb_x;
    logic [7:0]        fb_y;

    logic [2:0]        fb_mem [DEPTH];
    logic [2:0]        rd_data_q;

    logic [2:0]        pix_s1_q, pix_s1_d;
    logic              vis_s1_q, vis_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
    logic [2:0]        rgb_q, rgb_d;
    logic              hs_out_q, hs_out_d, vs_out_q, vs_out_d, blank_n_q, blank_n_d;

    vga_timing_gen #(
        .H_VIS (H_VIS), .H_FP (H_FP), .H_SW (H_SW), .H_BP (H_BP),
        .V_VIS (V_VIS), .V_FP (V_FP), .V_SW (V_SW), .V_BP (V_BP)
    ) u_timing (
        .clock      (clock),
        .reset      (reset),
        .pix_en     (pix_en),
        .fb_x       (fb_x),
        .fb_y       (fb_y),
        .visible    (visible),
        .hs_raw     (hs_raw),
        .vs_raw     (vs_raw),
        .frame_tick (frame_tick)
    );

    // FSM state and clear-address register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next state: a clear sweep walks every address once, then returns to IDLE.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = '0;
        case (state_q)
            IDLE: begin
                if (clear_screen) state_d = CLEAR;
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == MEM_AW'(DEPTH - 1)) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: write port control and drop decision (clear wins over a same-cycle plot).
    always_comb begin
        in_range = (x < 9'(FB_W)) && (y < 8'(FB_H));
        busy     = (state_q == CLEAR);
        we       = 1'b0;
        waddr    = MEM_AW'(fb_addr(x, y, FB_W));
        wdata    = colour;
        drop_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (plot) begin
                    if (in_range && !clear_screen) we = 1'b1;
                    else                           drop_d = 1'b1;
                end
            end
            CLEAR: begin
                we     = 1'b1;
                waddr  = clr_addr_q;
                wdata  = BACKGROUND;
                drop_d = plot;
            end
            default: ;
        endcase
    end

    // Scan-out read address; off-screen reads park on address 0.
    always_comb begin
        rd_addr = visible ? MEM_AW'(fb_addr(fb_x, fb_y, FB_W)) : '0;
    end

    // Frame buffer: one write port, registered read port (old data on collision).
    always_ff @(posedge clock) begin
        if (we) fb_mem[waddr] <= wdata;
        rd_data_q <= fb_mem[rd_addr];
    end

    // Two pixel-tick pipeline: RAM data stage, then output register; syncs follow the same path.
    always_comb begin
        pix_s1_d  = pix_s1_q;
        vis_s1_d  = vis_s1_q;
        hs_s1_d   = hs_s1_q;
        vs_s1_d   = vs_s1_q;
        rgb_d     = rgb_q;
        hs_out_d  = hs_out_q;
        vs_out_d  = vs_out_q;
        blank_n_d = blank_n_q;
        if (pix_en) begin
            pix_s1_d  = rd_data_q;
            vis_s1_d  = visible;
            hs_s1_d   = hs_raw;
            vs_s1_d   = vs_raw;
            rgb_d     = vis_s1_q ? pix_s1_q : 3'b000;
            hs_out_d  = hs_s1_q;
            vs_out_d  = vs_s1_q;
            blank_n_d = vis_s1_q;
        end
    end

    // Output and drop-pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_q    <= 1'b0;
            pix_s1_q  <= '0;
            vis_s1_q  <= 1'b0;
            hs_s1_q   <= 1'b1;
            vs_s1_q   <= 1'b1;
            rgb_q     <= '0;
            hs_out_q  <= 1'b1;
            vs_out_q  <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            drop_q    <= drop_d;
            pix_s1_q  <= pix_s1_d;
            vis_s1_q  <= vis_s1_d;
            hs_s1_q   <= hs_s1_d;
            vs_s1_q   <= vs_s1_d;
            rgb_q     <= rgb_d;
            hs_out_q  <= hs_out_d;
            vs_out_q  <= vs_out_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign plot_dropped = drop_q;
    assign vga_r        = {8{rgb_q[2]}};
    assign vga_g        = {8{rgb_q[1]}};
    assign vga_b        = {8{rgb_q[0]}};
    assign vga_hs       = hs_out_q;
    assign vga_vs       = vs_out_q;
    assign vga_blank_n  = blank_n_q;
    assign vga_sync_n   = 1'b0;
    assign vga_clk      = pix_en;

endmodule
